// File: rtl/draw_pkg.sv
// Shared types and constants for the frame draw sequencer and its helpers.
//   draw_state_t : sequencer FSM state encoding
//   X_W/Y_W/COLOUR_W : pixel coordinate and colour widths of the VGA adapter
//   WD_W : width of the per-source watchdog counter
//   DEF_SCREEN_W/DEF_SCREEN_H : visible screen size
package draw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAW,
    ST_RELEASE,
    ST_FINISH
  } draw_state_t;

  localparam int X_W          = 9;
  localparam int Y_W          = 8;
  localparam int COLOUR_W     = 6;
  localparam int WD_W         = 20;
  localparam int DEF_SCREEN_W = 320;
  localparam int DEF_SCREEN_H = 240;

endpackage

// File: rtl/draw_watchdog.sv
// Loadable up-counter with clear/enable and a terminal-count compare.
// Shared by the draw sequencer and the link/enemy movement timers.
// Ports:
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   clear             : zero the count (wins over load and enable)
//   load, load_value  : preset the count
//   enable            : count up by one
//   limit             : terminal count
//   expired           : count == limit
module draw_watchdog
  import draw_pkg::*;
#(
  parameter int W = WD_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == limit);

endmodule

// File: rtl/draw_sequencer.sv
// Frame draw sequencer and VGA write arbiter. On frame_start it runs the
// draw/draw_done handshake with each sprite source in index order and
// forwards the active source's pixels to the single VGA write port.
// Optional build macro: DRAW_CLIP_EN drops pixels outside the visible screen.
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   frame_start         : one-cycle frame request (honoured only when idle)
//   src_draw            : one-hot draw enable per source
//   src_x/y/colour      : packed per-source pixel streams, source i in slice i
//   src_write, src_done : per-source pixel valid and draw_done
//   vga_x/y/colour/plot : registered pixel write to the adapter
//   busy                : frame in progress
//   frame_done          : one-cycle pulse at the end of a frame
//   timeout_err         : sticky, a source overran the watchdog
//
// state   | meaning
// IDLE    | no draw active, waiting for frame_start
// DRAW    | src_draw[idx] high, forwarding pixels until done or watchdog
// RELEASE | draw dropped, waiting for src_done[idx] to fall (or watchdog)
// FINISH  | frame_done pulse, back to IDLE
module draw_sequencer
  import draw_pkg::*;
#(
  parameter int              NUM_SRC    = 4,
  parameter int              SCREEN_W   = DEF_SCREEN_W,
  parameter int              SCREEN_H   = DEF_SCREEN_H,
  parameter logic [WD_W-1:0] MAX_CYCLES = 20'd131071
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         frame_start,
  output logic [NUM_SRC-1:0]           src_draw,
  input  logic [X_W*NUM_SRC-1:0]       src_x,
  input  logic [Y_W*NUM_SRC-1:0]       src_y,
  input  logic [COLOUR_W*NUM_SRC-1:0]  src_colour,
  input  logic [NUM_SRC-1:0]           src_write,
  input  logic [NUM_SRC-1:0]           src_done,
  output logic [X_W-1:0]               vga_x,
  output logic [Y_W-1:0]               vga_y,
  output logic [COLOUR_W-1:0]          vga_colour,
  output logic                         vga_plot,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         timeout_err
);

  localparam int               IDX_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_SRC - 1);
  localparam logic [X_W:0]     SCREEN_W_L = (X_W + 1)'(SCREEN_W);
  localparam logic [Y_W:0]     SCREEN_H_L = (Y_W + 1)'(SCREEN_H);
`ifdef DRAW_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  draw_state_t state, state_next;
  logic [IDX_W-1:0] idx, idx_next;
  logic err_set;
  logic wd_clear, wd_enable, wd_expired;

  logic [X_W-1:0]      x_arr      [NUM_SRC];
  logic [Y_W-1:0]      y_arr      [NUM_SRC];
  logic [COLOUR_W-1:0] colour_arr [NUM_SRC];

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
    assign x_arr[g]      = src_x[g*X_W +: X_W];
    assign y_arr[g]      = src_y[g*Y_W +: Y_W];
    assign colour_arr[g] = src_colour[g*COLOUR_W +: COLOUR_W];
  end

  logic                cur_write, cur_done, in_screen, forward;
  logic [X_W-1:0]      sel_x;
  logic [Y_W-1:0]      sel_y;
  logic [COLOUR_W-1:0] sel_colour;

  assign cur_write  = src_write[idx];
  assign cur_done   = src_done[idx];
  assign sel_x      = x_arr[idx];
  assign sel_y      = y_arr[idx];
  assign sel_colour = colour_arr[idx];
  assign in_screen  = ({1'b0, sel_x} < SCREEN_W_L) && ({1'b0, sel_y} < SCREEN_H_L);
  // done takes priority over write so the completion cycle never plots
  assign forward    = (state == ST_DRAW) && cur_write && !cur_done && (!CLIP_EN || in_screen);

  always_comb begin
    state_next = state;
    idx_next   = idx;
    err_set    = 1'b0;
    src_draw   = '0;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (frame_start) begin
          state_next = ST_DRAW;
          idx_next   = '0;
        end
      end
      ST_DRAW: begin
        src_draw[idx] = 1'b1;
        busy          = 1'b1;
        if (cur_done) begin
          state_next = ST_RELEASE;
        end else if (wd_expired) begin
          state_next = ST_RELEASE;
          err_set    = 1'b1;
        end
      end
      ST_RELEASE: begin
        busy = 1'b1;
        // a source that never drops done is forced out by the watchdog
        if (!cur_done || wd_expired) begin
          err_set = cur_done;
          if (idx == LAST_IDX) begin
            state_next = ST_FINISH;
          end else begin
            idx_next   = idx + 1'b1;
            state_next = ST_DRAW;
          end
        end
      end
      ST_FINISH: begin
        frame_done = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // restarting on every state change gives DRAW and RELEASE their own budget
  assign wd_clear  = (state_next != state);
  assign wd_enable = (state == ST_DRAW) || (state == ST_RELEASE);

  draw_watchdog #(.W(WD_W)) u_watchdog (
    .clock      (clock),
    .reset      (reset),
    .clear      (wd_clear),
    .load       (1'b0),
    .load_value ('0),
    .enable     (wd_enable),
    .limit      (MAX_CYCLES - 1'b1),
    .expired    (wd_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      idx         <= '0;
      timeout_err <= 1'b0;
      vga_x       <= '0;
      vga_y       <= '0;
      vga_colour  <= '0;
      vga_plot    <= 1'b0;
    end else begin
      state    <= state_next;
      idx      <= idx_next;
      vga_plot <= forward;
      if (err_set) begin
        timeout_err <= 1'b1;
      end
      if (forward) begin
        vga_x      <= sel_x;
        vga_y      <= sel_y;
        vga_colour <= sel_colour;
      end
    end
  end

endmodule

// File: tb/tb_draw_sequencer.sv
// Self-checking bench for draw_sequencer. Behavioural sprite sources answer
// the draw/done handshake; expected plots, frame lengths and flags come from
// the handshake timing rules applied to each source's pixel list.
module tb_draw_sequencer;
  import draw_pkg::*;

  localparam int        N    = 4;
  localparam logic [19:0] MAXC = 20'd16;
`ifdef DRAW_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset, frame_start;
  logic [N-1:0]   src_draw, src_write, src_done;
  logic [9*N-1:0] src_x;
  logic [8*N-1:0] src_y;
  logic [6*N-1:0] src_colour;
  logic [8:0] vga_x;
  logic [7:0] vga_y;
  logic [5:0] vga_colour;
  logic vga_plot, busy, frame_done, timeout_err;

  draw_sequencer #(.NUM_SRC(N), .MAX_CYCLES(MAXC)) dut (
    .clock(clock), .reset(reset), .frame_start(frame_start),
    .src_draw(src_draw), .src_x(src_x), .src_y(src_y), .src_colour(src_colour),
    .src_write(src_write), .src_done(src_done),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // source model: mode 0 normal, 1 never raises done, 2 done stuck high
  int          n_pix [N];
  int          mode [N];
  logic [22:0] pix [N][8];
  int          emitted [N];
  int          gaps_left [N];
  bit          d_prev [N];
  bit          done_lat [N];
  int          gap_pct;

  logic [22:0] exp_q [$];
  int          draw_cycles [N];
  int          n_done;
  int          n_plots;

  typedef struct {
    logic [8:0] x;
    logic [7:0] y;
    logic [5:0] c;
    bit         plot_clip;
  } clip_vec_t;
  clip_vec_t cv [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bit visible(input logic [8:0] x, input logic [7:0] y);
    return !CLIP || ((int'(x) < 320) && (int'(y) < 240));
  endfunction

  // cycles from frame_start to frame_done for gap-free sources
  function automatic int model_len();
    int t = 1;
    for (int i = 0; i < N; i++) begin
      case (mode[i])
        0:       t += n_pix[i] + 4;
        1:       t += int'(MAXC) + 1;
        default: t += n_pix[i] + 2 + int'(MAXC);
      endcase
    end
    return t;
  endfunction

  task automatic setup_frame();
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      emitted[i]   = 0;
      gaps_left[i] = 3;
      done_lat[i]  = 1'b0;
      for (int k = 0; k < n_pix[i]; k++)
        if (visible(pix[i][k][22:14], pix[i][k][13:6])) exp_q.push_back(pix[i][k]);
    end
  endtask

  task automatic drive_sources();
    for (int i = 0; i < N; i++) begin
      logic w, dn;
      logic [22:0] p;
      w = 1'b0;
      dn = 1'b0;
      p = 23'($urandom);
      if (mode[i] == 2 && done_lat[i]) begin
        dn = 1'b1;
      end else if (d_prev[i]) begin
        if (emitted[i] < n_pix[i]) begin
          if (gaps_left[i] > 0 && $urandom_range(0, 99) < gap_pct) begin
            gaps_left[i]--;
          end else begin
            w = 1'b1;
            p = pix[i][emitted[i]];
            emitted[i]++;
          end
        end else if (mode[i] != 1) begin
          dn = 1'b1;
          if (mode[i] == 2) done_lat[i] = 1'b1;
        end
      end
      src_write[i]          = w;
      src_done[i]           = dn;
      src_x[9*i +: 9]       = p[22:14];
      src_y[8*i +: 8]       = p[13:6];
      src_colour[6*i +: 6]  = p[5:0];
      d_prev[i]             = src_draw[i];
    end
  endtask

  task automatic monitor();
    if (vga_plot === 1'b1) begin
      n_plots++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL extra_plot: got pixel %0h, expected no plot", {vga_x, vga_y, vga_colour});
      end else begin
        check("plot_pixel", 32'({vga_x, vga_y, vga_colour}), 32'(exp_q.pop_front()));
      end
    end
    if (frame_done === 1'b1) begin
      n_done++;
      check("busy_low_at_done", 32'(busy), 32'(0));
    end
    for (int i = 0; i < N; i++)
      if (src_draw[i] === 1'b1) draw_cycles[i]++;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    monitor();
    drive_sources();
  endtask

  task automatic run_frame(input int exp_len, input int req_src, input bit start_on_done);
    int len;
    bit pulsed;
    for (int i = 0; i < N; i++) draw_cycles[i] = 0;
    n_done = 0;
    n_plots = 0;
    pulsed = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    len = 1;
    check("busy_rise", 32'(busy), 32'(1));
    check("first_draw", 32'(src_draw), 32'(1));
    while (frame_done !== 1'b1 && len < 600) begin
      if (req_src >= 0 && !pulsed && src_draw[req_src] === 1'b1) begin
        frame_start = 1'b1;
        pulsed = 1'b1;
      end
      tick();
      frame_start = 1'b0;
      len++;
    end
    check("frame_done_seen", 32'(frame_done), 32'(1));
    if (exp_len >= 0) check("frame_len", 32'(len), 32'(exp_len));
    if (start_on_done) frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("idle_after_busy", 32'(busy), 32'(0));
    check("idle_after_draw", 32'(src_draw), 32'(0));
    tick();
    tick();
    check("single_frame_done", 32'(n_done), 32'(1));
    check("all_pixels_plotted", 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int w;
    bit exp_plot;
    reset = 1'b1;
    frame_start = 1'b0;
    src_write = '0;
    src_done = '0;
    src_x = '0;
    src_y = '0;
    src_colour = '0;
    gap_pct = 0;
    for (int i = 0; i < N; i++) begin
      mode[i] = 0;
      n_pix[i] = 0;
      d_prev[i] = 1'b0;
      done_lat[i] = 1'b0;
      emitted[i] = 0;
      gaps_left[i] = 0;
    end

    cv[0] = '{9'd320, 8'd10,  6'd5,  1'b0};
    cv[1] = '{9'd319, 8'd239, 6'd9,  1'b1};
    cv[2] = '{9'd0,   8'd240, 6'd17, 1'b0};
    cv[3] = '{9'd0,   8'd0,   6'd33, 1'b1};
    cv[4] = '{9'd511, 8'd255, 6'd63, 1'b0};
    cv[5] = '{9'd100, 8'd239, 6'd2,  1'b1};

    repeat (3) tick();
    check("rst_src_draw", 32'(src_draw), 32'(0));
    check("rst_vga_plot", 32'(vga_plot), 32'(0));
    check("rst_vga_x", 32'(vga_x), 32'(0));
    check("rst_vga_y", 32'(vga_y), 32'(0));
    check("rst_vga_colour", 32'(vga_colour), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_frame_done", 32'(frame_done), 32'(0));
    check("rst_timeout_err", 32'(timeout_err), 32'(0));
    reset = 1'b0;
    tick();

    // normal frame: three on-screen pixels per source
    for (int i = 0; i < N; i++) begin
      n_pix[i] = 3;
      for (int k = 0; k < 3; k++)
        pix[i][k] = {9'(10*i + k + 1), 8'(20 + 3*i + k), 6'(8*i + k + 1)};
    end
    setup_frame();
    run_frame(model_len(), -1, 1'b0);
    check("normal_plot_count", 32'(n_plots), 32'(12));
    check("normal_timeout", 32'(timeout_err), 32'(0));

    // immediate done, plus a frame_start coinciding with frame_done
    for (int i = 0; i < N; i++) n_pix[i] = 0;
    setup_frame();
    run_frame(17, -1, 1'b1);
    check("immediate_plot_count", 32'(n_plots), 32'(0));

    // clipping vectors, one pixel from source 0 per frame
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < N; i++) n_pix[i] = 0;
      n_pix[0] = 1;
      pix[0][0] = {cv[v].x, cv[v].y, cv[v].c};
      setup_frame();
      exp_q.delete();
      exp_plot = CLIP ? cv[v].plot_clip : 1'b1;
      if (exp_plot) exp_q.push_back(pix[0][0]);
      run_frame(model_len(), -1, 1'b0);
      check("clip_plot_count", 32'(n_plots), 32'(exp_plot));
    end

    // random pixel streams with idle gaps
    gap_pct = 30;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < N; i++) begin
        n_pix[i] = int'($urandom_range(0, 5));
        for (int k = 0; k < 8; k++) pix[i][k] = 23'($urandom);
      end
      setup_frame();
      run_frame(-1, -1, 1'b0);
      check("random_timeout", 32'(timeout_err), 32'(0));
    end
    gap_pct = 0;

    // frame_start while source 1 draws must be ignored
    for (int i = 0; i < N; i++) begin
      n_pix[i] = 3;
      for (int k = 0; k < 3; k++)
        pix[i][k] = {9'(40*i + k + 7), 8'(5*i + k + 3), 6'(i + 4*k + 1)};
    end
    setup_frame();
    run_frame(model_len(), 1, 1'b0);
    check("no_restart_src0", 32'(draw_cycles[0]), 32'(n_pix[0] + 2));

    // source 2 never raises done
    mode[2] = 1;
    n_pix[2] = 2;
    setup_frame();
    run_frame(model_len(), -1, 1'b0);
    check("stuck_draw_cycles", 32'(draw_cycles[2]), 32'(MAXC));
    check("stuck_src3_drawn", 32'(draw_cycles[3]), 32'(n_pix[3] + 2));
    check("stuck_timeout_err", 32'(timeout_err), 32'(1));
    mode[2] = 0;
    n_pix[2] = 3;
    setup_frame();
    run_frame(model_len(), -1, 1'b0);
    check("timeout_sticky", 32'(timeout_err), 32'(1));

    // reset while source 1 is mid-stream
    setup_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    w = 0;
    while (src_draw[1] !== 1'b1 && w < 100) begin
      tick();
      w++;
    end
    check("reached_src1", 32'(src_draw[1]), 32'(1));
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_src_draw", 32'(src_draw), 32'(0));
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_vga_plot", 32'(vga_plot), 32'(0));
    check("mid_rst_vga_x", 32'(vga_x), 32'(0));
    check("mid_rst_vga_y", 32'(vga_y), 32'(0));
    check("mid_rst_vga_colour", 32'(vga_colour), 32'(0));
    check("mid_rst_frame_done", 32'(frame_done), 32'(0));
    check("mid_rst_timeout_err", 32'(timeout_err), 32'(0));
    exp_q.delete();
    tick();
    check("mid_rst_idle", 32'(src_draw), 32'(0));
    setup_frame();
    run_frame(model_len(), -1, 1'b0);
    check("restart_timeout", 32'(timeout_err), 32'(0));

    // source 1 holds done high after draw falls
    for (int i = 0; i < N; i++) n_pix[i] = 0;
    mode[1] = 2;
    setup_frame();
    run_frame(model_len(), -1, 1'b0);
    check("release_timeout_err", 32'(timeout_err), 32'(1));
    check("release_src2_drawn", 32'(draw_cycles[2]), 32'(2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/draw_sequencer.md
# draw_sequencer

Frame-level draw sequencer and VGA write arbiter that drives the `draw`/`draw_done` handshake of each sprite source (background, link, enemy group, HUD) in fixed order. It muxes the active source's pixel stream onto the single VGA adapter write port. It sits between the top-level game control FSM, which pulses `frame_start`, and the VGA adapter. Each frame it reports completion with a `frame_done` pulse.

## Interface
- `NUM_SRC`, default 4: number of sprite sources; source 0 is drawn first.
- `SCREEN_W`, default 320: visible width in pixels.
- `SCREEN_H`, default 240: visible height in pixels.
- `MAX_CYCLES`, default 20'd131071: watchdog limit per source, in cycles.
- `clock` in 1: system clock; all logic is rising-edge.
- `reset` in 1: synchronous, active-high.
- `frame_start` in 1: one-cycle request to draw a frame.
- `src_draw` out NUM_SRC: one-hot draw enable per source.
- `src_x` in 9*NUM_SRC: packed pixel x; source i occupies bits [9i+8:9i].
- `src_y` in 8*NUM_SRC: packed pixel y.
- `src_colour` in 6*NUM_SRC: packed 6-bit colour.
- `src_write` in NUM_SRC: pixel valid per source.
- `src_done` in NUM_SRC: per-source draw_done.
- `vga_x` out 9: registered pixel x to the adapter.
- `vga_y` out 8: registered pixel y.
- `vga_colour` out 6: registered colour.
- `vga_plot` out 1: registered write enable.
- `busy` out 1: high from frame acceptance until `frame_done`.
- `frame_done` out 1: one-cycle pulse when all sources have finished.
- `timeout_err` out 1: sticky; set when any source exceeds MAX_CYCLES.

## Operation
- Source handshake:
  - The sequencer raises `src_draw[i]` and holds it.
  - The source streams pixels using `src_write[i]` and then raises `src_done[i]`, holding it while `src_draw[i]` is high.
  - The source drops `src_done[i]` one or more cycles after `src_draw[i]` falls.
- States:
  - IDLE: `src_draw`=0. `frame_start` → DRAW, with idx=0 and the watchdog cleared.
  - DRAW: `src_draw[idx]`=1. `src_done[idx]` or watchdog expiry → RELEASE. Expiry also sets `timeout_err`.
  - RELEASE: `src_draw`=0. Wait for `src_done[idx]`=0. Then, if idx==NUM_SRC-1, go to FINISH; otherwise increment idx and go to DRAW.
  - FINISH: pulse `frame_done`, drop `busy`, go to IDLE.
- Pixel forwarding: when state==DRAW, `src_write[idx]`=1 and `src_done[idx]`=0, register the idx slice into the `vga_*` outputs with `vga_plot`=1. Otherwise `vga_plot`=0 and `vga_x`/`vga_y`/`vga_colour` hold their previous values.
- No pixel is forwarded in the cycle `src_done[idx]` is first seen, even if `src_write[idx]` is also high.
- Watchdog:
  - A 20-bit counter clears on each DRAW entry and increments every DRAW cycle.
  - Expiry occurs when the count equals MAX_CYCLES-1.
  - In RELEASE, a source stuck with done high is also released after MAX_CYCLES; this sets `timeout_err`.
- `frame_start` is ignored unless in IDLE. A `frame_start` in the same cycle as `frame_done` is ignored.
- Reset in any state returns to IDLE in the next cycle, cleanly aborting any mid-frame draw. All outputs go to 0, including `timeout_err`, idx, and the watchdog.

## Timing
- `frame_start` → `src_draw[0]` high: 1 cycle.
- Source pixel → `vga_plot`: 1 cycle latency, registered.
- `src_done[i]` high → `src_draw[i]` low: 1 cycle.
- `src_done[i]` low → `src_draw[i+1]` high: 1 cycle.
- Minimum frame with every source done immediately: 4*NUM_SRC+1 cycles from `frame_start` to `frame_done`.
- `busy` rises on the cycle after `frame_start` and falls with the `frame_done` pulse cycle.

## Configuration
- `DRAW_CLIP_EN`:
  - Defined: a pixel with x ≥ SCREEN_W or y ≥ SCREEN_H is dropped (`vga_plot`=0). Comparison is unsigned on the full 9/8-bit width.
  - Undefined: all valid pixels are forwarded unchanged, and the adapter handles out-of-range addresses.

## Structure
- Shared package `draw_pkg`:
  - state enum (IDLE, DRAW, RELEASE, FINISH);
  - X_W=9, Y_W=8, COLOUR_W=6;
  - default SCREEN_W/SCREEN_H.
- Sub-module `draw_watchdog`: loadable 20-bit counter with clear, enable, and an `expired` output. It is reused by the link and enemy movement timers.

## Test plan
- **Normal frame:** NUM_SRC=4 with model sources that each write 3 pixels and then finish, after `frame_start`. Expect 12 `vga_plot` pulses in source order, one `frame_done` at the end, `busy` low afterwards, and `timeout_err`=0.
- **Immediate done:** every source raises done the cycle after draw. Expect `frame_done` exactly 17 cycles after `frame_start`, with zero plots.
- **Stuck source:** source 2 never raises done, MAX_CYCLES=16. Expect `src_draw[2]` to drop after 16 cycles, `timeout_err`=1 (sticky), source 3 still drawn, and `frame_done` asserted.
- **Clipping:** with `DRAW_CLIP_EN`, source writes at (320,10), (319,239), (0,240). Expect only (319,239) plotted. Without the macro, all 3 are plotted.
- **Reset mid-frame:** assert reset while source 1 is drawing. Expect all outputs 0 and state IDLE next cycle. A new `frame_start` then restarts from source 0.
- **Busy re-request:** pulse `frame_start` during source 1. Expect it ignored, exactly one `frame_done`, and no restart.
